// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the multiply/divide unit and the decoder that drives it.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MD_MFHI  = 3'b000,
        MD_MFLO  = 3'b001,
        MD_MTHI  = 3'b010,
        MD_MTLO  = 3'b011,
        MD_MULT  = 3'b100,
        MD_MULTU = 3'b101,
        MD_DIV   = 3'b110,
        MD_DIVU  = 3'b111
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;
    logic             div_zero;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, hi, lo, rd_data, div_zero
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, hi, lo, rd_data, div_zero
    );
endinterface

// File: rtl/mdu_seq_arith.sv
// Combinational mult/div datapath: full HI/LO result for an operation plus a zero-divisor flag.
module mdu_seq_arith
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             dz
);
    localparam int unsigned W2 = 2 * WIDTH;

    logic             is_signed;
    logic [W2-1:0]    ext_a;
    logic [W2-1:0]    ext_b;
    logic [W2-1:0]    prod;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    assign is_signed = ~op[0];

    // Sign/zero extension to 2*WIDTH makes one truncating multiply exact for both flavours.
    assign ext_a = {{WIDTH{is_signed & rs_val[WIDTH-1]}}, rs_val};
    assign ext_b = {{WIDTH{is_signed & rt_val[WIDTH-1]}}, rt_val};
    assign prod  = ext_a * ext_b;

    assign neg_a = is_signed & rs_val[WIDTH-1];
    assign neg_b = is_signed & rt_val[WIDTH-1];
    assign mag_a = neg_a ? -rs_val : rs_val;
    assign mag_b = neg_b ? -rt_val : rt_val;
    assign dz    = op[2] & op[1] & (rt_val == '0);

    // MIN magnitude wraps to MIN; negating the quotient of MIN/-1 then yields MIN, remainder 0.
    assign div_b = dz ? WIDTH'(1) : mag_b;
    assign q_mag = mag_a / div_b;
    assign r_mag = mag_a % div_b;
    assign quot  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem   = neg_a ? -r_mag : r_mag;

    always_comb begin
        hi_next = '0;
        lo_next = '0;
        if (op[2]) begin
            if (op[1]) begin
                hi_next = rem;
                lo_next = quot;
            end else begin
                hi_next = prod[W2-1:WIDTH];
                lo_next = prod[WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// EX-stage multi-cycle multiply/divide unit: HI/LO registers, latency counter and flush cancel.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic      clk,
    input logic      rst,
    mdu_seq_if.slave md
);
    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic             dz;
    logic             issue;

    mdu_seq_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op      (md.op),
        .rs_val  (md.rs_val),
        .rt_val  (md.rt_val),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .dz      (dz)
    );

    assign issue = md.start & ~md.flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_dz_d  = pend_dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    if (md.op[2]) begin
                        state_d   = ST_RUN;
                        cnt_d     = md.op[1] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                        pend_hi_d = hi_next;
                        pend_lo_d = lo_next;
                        pend_dz_d = dz;
                    end else if (md.op[1]) begin
                        if (md.op[0]) begin
                            lo_d = md.rs_val;
                        end else begin
                            hi_d = md.rs_val;
                        end
                    end
                end
            end
            ST_RUN: begin
                // Flush beats completion so a cancelled op never touches HI/LO.
                if (md.flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pend_dz_q) begin
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_dz_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_dz_q  <= pend_dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign md.busy     = (state_q == ST_RUN);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.div_zero = div_zero_q;
    assign md.rd_data  = (md.start && md.op[2:1] == 2'b00) ? (md.op[0] ? lo_q : hi_q) : '0;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed plan cases plus randomized ops against a plain model.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) mif ();
    mdu_seq_if #(.WIDTH(16)) nif ();

    mdu_seq #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .md  (mif)
    );

    mdu_seq #(
        .WIDTH      (16),
        .MUL_CYCLES (1),
        .DIV_CYCLES (3)
    ) dut_n (
        .clk (clk),
        .rst (rst),
        .md  (nif)
    );

    // Reference: HI/LO after one op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, output logic dz);
        int          sa, sb;
        longint      la, lb, p, q, r;
        logic [63:0] up;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        dz = 1'b0;
        case (o)
            MD_MULT:  begin p = la * lb; h = p[63:32]; l = p[31:0]; end
            MD_MULTU: begin up = 64'(a) * 64'(b); h = up[63:32]; l = up[31:0]; end
            MD_DIV: begin
                if (b == 0) dz = 1'b1;
                else begin q = la / lb; r = la % lb; h = r[31:0]; l = q[31:0]; end
            end
            MD_DIVU: begin
                if (b == 0) dz = 1'b1;
                else begin h = a % b; l = a / b; end
            end
            MD_MTHI: h = a;
            MD_MTLO: l = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        mif.start = 1'b1; mif.op = o; mif.rs_val = a; mif.rt_val = b;
        @(posedge clk); #1;
        mif.start = 1'b0; mif.op = 3'b000;
    endtask

    // Counts busy cycles seen at negedges; returns at the first cycle with busy low.
    task automatic wait_done(output int cycles, output logic dz_seen);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            if (!mif.busy || cycles > 200) break;
            cycles++;
        end
        dz_seen = mif.div_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mif.busy !== 1'b0 || mif.hi !== 32'h0 || mif.lo !== 32'h0 || mif.div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: busy=%b hi=%h lo=%h dz=%b, want 0/0/0/0",
                     mif.busy, mif.hi, mif.lo, mif.div_zero);
        end
        vectors++;
        if (nif.busy !== 1'b0 || nif.hi !== 16'h0 || nif.lo !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_narrow: busy=%b hi=%h lo=%h, want 0/0/0", nif.busy, nif.hi, nif.lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_mult();
        int   c;
        logic z;
        logic [2:0]  ops [2] = '{MD_MULT, MD_MULTU};
        logic [31:0] as  [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
        logic [31:0] bs  [2] = '{32'd7, 32'hFFFFFFFF};
        logic [31:0] eh  [2] = '{32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] el  [2] = '{32'hFFFFFFEB, 32'h00000001};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(c, z);
            vectors++;
            if (c !== 5) begin
                miscompares++;
                $display("FAIL mult%0d_latency: busy %0d cycles, want 5", i, c);
            end
            vectors++;
            if (mif.hi !== eh[i] || mif.lo !== el[i] || z !== 1'b0) begin
                miscompares++;
                $display("FAIL mult%0d_result: hi=%h lo=%h dz=%b, want %h %h 0",
                         i, mif.hi, mif.lo, z, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_div();
        int   c;
        logic z;
        logic [2:0]  ops [3] = '{MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
        logic [31:0] eh  [3] = '{32'hFFFFFFFF, 32'd1, 32'h0};
        logic [31:0] el  [3] = '{32'hFFFFFFFD, 32'd3, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(c, z);
            vectors++;
            if (c !== 10) begin
                miscompares++;
                $display("FAIL div%0d_latency: busy %0d cycles, want 10", i, c);
            end
            vectors++;
            if (mif.hi !== eh[i] || mif.lo !== el[i] || z !== 1'b0) begin
                miscompares++;
                $display("FAIL div%0d_result: hi=%h lo=%h dz=%b, want %h %h 0",
                         i, mif.hi, mif.lo, z, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_mt_div_zero();
        int   c;
        logic z;
        issue(MD_MTHI, 32'h12, 32'h0);
        @(negedge clk);
        vectors++;
        if (mif.busy !== 1'b0 || mif.hi !== 32'h12) begin
            miscompares++;
            $display("FAIL mthi: busy=%b hi=%h, want 0 00000012", mif.busy, mif.hi);
        end
        issue(MD_MTLO, 32'h34, 32'h0);
        @(negedge clk);
        vectors++;
        if (mif.busy !== 1'b0 || mif.lo !== 32'h34) begin
            miscompares++;
            $display("FAIL mtlo: busy=%b lo=%h, want 0 00000034", mif.busy, mif.lo);
        end
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_done(c, z);
        vectors++;
        if (c !== 10 || z !== 1'b1) begin
            miscompares++;
            $display("FAIL divzero_pulse: busy %0d cycles dz=%b, want 10 1", c, z);
        end
        vectors++;
        if (mif.hi !== 32'h12 || mif.lo !== 32'h34) begin
            miscompares++;
            $display("FAIL divzero_hilo: hi=%h lo=%h, want 00000012 00000034", mif.hi, mif.lo);
        end
        @(negedge clk);
        vectors++;
        if (mif.div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL divzero_width: dz=%b one cycle later, want 0", mif.div_zero);
        end
        @(posedge clk); #1;
        mif.start = 1'b1; mif.op = MD_MFHI;
        #1;
        vectors++;
        if (mif.rd_data !== 32'h12) begin
            miscompares++;
            $display("FAIL mfhi: rd_data=%h, want 00000012", mif.rd_data);
        end
        mif.op = MD_MFLO;
        #1;
        vectors++;
        if (mif.rd_data !== 32'h34) begin
            miscompares++;
            $display("FAIL mflo: rd_data=%h, want 00000034", mif.rd_data);
        end
        mif.start = 1'b0;
        #1;
        vectors++;
        if (mif.rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rd_idle: rd_data=%h, want 0", mif.rd_data);
        end
    endtask

    task automatic test_flush();
        int hits;
        issue(MD_DIV, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk); #1;
        mif.flush = 1'b1;
        @(posedge clk); #1;
        mif.flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (mif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy: busy=%b after flush, want 0", mif.busy);
        end
        issue(MD_DIVU, 32'd9, 32'd0);
        @(posedge clk); #1;
        mif.flush = 1'b1;
        @(posedge clk); #1;
        mif.flush = 1'b0;
        hits = 0;
        repeat (14) begin
            @(negedge clk);
            if (mif.div_zero || mif.busy) hits++;
        end
        vectors++;
        if (hits !== 0 || mif.hi !== 32'h12 || mif.lo !== 32'h34) begin
            miscompares++;
            $display("FAIL flush_cancel: busy/dz hits=%0d hi=%h lo=%h, want 0 00000012 00000034",
                     hits, mif.hi, mif.lo);
        end
        @(posedge clk); #1;
        mif.start = 1'b1; mif.op = MD_MULT; mif.rs_val = 32'd3; mif.rt_val = 32'd3;
        mif.flush = 1'b1;
        @(posedge clk); #1;
        mif.op = MD_MTHI; mif.rs_val = 32'hBAD;
        @(posedge clk); #1;
        mif.start = 1'b0; mif.flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (mif.busy !== 1'b0 || mif.hi !== 32'h12) begin
            miscompares++;
            $display("FAIL flush_start: busy=%b hi=%h, want 0 00000012", mif.busy, mif.hi);
        end
    endtask

    task automatic test_ignored_start();
        int   c;
        logic z;
        issue(MD_MULT, 32'd3, 32'd4);
        @(posedge clk); #1;
        mif.start = 1'b1; mif.op = MD_MULT; mif.rs_val = 32'd5; mif.rt_val = 32'd6;
        @(posedge clk); #1;
        mif.op = MD_MTHI; mif.rs_val = 32'hDEAD;
        @(posedge clk); #1;
        mif.op = MD_MFHI;
        #1;
        vectors++;
        if (mif.rd_data !== 32'h12) begin
            miscompares++;
            $display("FAIL mfhi_busy: rd_data=%h, want 00000012", mif.rd_data);
        end
        mif.start = 1'b0;
        wait_done(c, z);
        vectors++;
        if (c !== 2 || mif.hi !== 32'h0 || mif.lo !== 32'd12) begin
            miscompares++;
            $display("FAIL ignored_start: tail %0d cycles hi=%h lo=%h, want 2 0 0000000c",
                     c, mif.hi, mif.lo);
        end
    endtask

    task automatic test_random();
        logic [2:0]  ops [6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        logic [31:0] h_m, l_m, a, b;
        logic [2:0]  o;
        logic        dz_m, z;
        int          c;
        h_m = $urandom;
        l_m = $urandom;
        issue(MD_MTHI, h_m, 32'h0);
        issue(MD_MTLO, l_m, 32'h0);
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 30);
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            model(o, a, b, h_m, l_m, dz_m);
            issue(o, a, b);
            if (o[2]) begin
                wait_done(c, z);
                vectors++;
                if (c !== (o[1] ? 10 : 5) || z !== dz_m) begin
                    miscompares++;
                    $display("FAIL rand%0d_timing: op=%b busy %0d dz=%b, want %0d %b",
                             i, o, c, z, o[1] ? 10 : 5, dz_m);
                end
            end else begin
                @(negedge clk);
                vectors++;
                if (mif.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand%0d_mt_busy: busy=%b, want 0", i, mif.busy);
                end
            end
            vectors++;
            if (mif.hi !== h_m || mif.lo !== l_m) begin
                miscompares++;
                $display("FAIL rand%0d_result: op=%b a=%h b=%h hi=%h lo=%h, want %h %h",
                         i, o, a, b, mif.hi, mif.lo, h_m, l_m);
            end
        end
    endtask

    task automatic test_async_reset();
        issue(MD_MTHI, 32'hAAAA, 32'h0);
        issue(MD_MTLO, 32'h5555, 32'h0);
        issue(MD_DIV, 32'd1000, 32'd3);
        @(posedge clk); #2;
        vectors++;
        if (mif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: busy=%b mid-divide, want 1", mif.busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (mif.busy !== 1'b0 || mif.hi !== 32'h0 || mif.lo !== 32'h0) begin
            miscompares++;
            $display("FAIL areset: busy=%b hi=%h lo=%h before any edge, want 0 0 0",
                     mif.busy, mif.hi, mif.lo);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_narrow();
        logic [2:0]  ops [2] = '{MD_MULT, MD_DIV};
        logic [15:0] as  [2] = '{16'hFFFD, 16'hFFF9};
        logic [15:0] bs  [2] = '{16'd7, 16'd2};
        logic [15:0] eh  [2] = '{16'hFFFF, 16'hFFFF};
        logic [15:0] el  [2] = '{16'hFFEB, 16'hFFFD};
        int          lat [2] = '{1, 3};
        int          c;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            nif.start = 1'b1; nif.op = ops[i]; nif.rs_val = as[i]; nif.rt_val = bs[i];
            @(posedge clk); #1;
            nif.start = 1'b0; nif.op = 3'b000;
            c = 0;
            while (1) begin
                @(negedge clk);
                if (!nif.busy || c > 50) break;
                c++;
            end
            vectors++;
            if (c !== lat[i] || nif.hi !== eh[i] || nif.lo !== el[i]) begin
                miscompares++;
                $display("FAIL narrow%0d: busy %0d hi=%h lo=%h, want %0d %h %h",
                         i, c, nif.hi, nif.lo, lat[i], eh[i], el[i]);
            end
        end
    endtask

    initial begin
        mif.start = 1'b0; mif.op = 3'b000; mif.rs_val = '0; mif.rt_val = '0; mif.flush = 1'b0;
        nif.start = 1'b0; nif.op = 3'b000; nif.rs_val = '0; nif.rt_val = '0; nif.flush = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mt_div_zero();
        test_flush();
        test_ignored_start();
        test_random();
        test_async_reset();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage of the 5-stage pipeline.
It accepts one operation per start pulse from the decoder's md_start/md_control outputs and models configurable mult/div latency.
It raises busy while an operation is in flight, which feeds the decoder's block stall term.
It extends the existing md interface with flush cancellation, divide-by-zero reporting, and configurable width and latency.

Parameters:
WIDTH, 32, operand and HI/LO width in bits.
MUL_CYCLES, 5, cycles from mult/multu issue to HI/LO update; must be >= 1.
DIV_CYCLES, 10, cycles from div/divu issue to HI/LO update; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  issue strobe, equal to md_start, qualified by the EX valid bit.
op  input  3  operation, equal to md_control: 100 mult, 101 multu, 110 div, 111 divu, 010 mthi, 011 mtlo, 000 mfhi, 001 mflo.
rs_val  input  WIDTH  forwarded rs operand.
rt_val  input  WIDTH  forwarded rt operand.
flush  input  1  cancels any in-flight mult/div and suppresses a same-cycle start.
busy  output  1  a mult/div is in flight.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
rd_data  output  WIDTH  mfhi/mflo result to the EX result mux.
div_zero  output  1  one-cycle pulse when a div/divu with rt_val==0 completes.

Behaviour:
- Reset (async, immediate): hi=0, lo=0, busy=0, div_zero=0, state=IDLE, counter=0, pending result cleared.
- States:
  - IDLE: accepts start.
  - RUN: counter counts down from the latency value.
- Transitions:
  - IDLE -> RUN on start & ~flush & op[2].
  - RUN -> IDLE when counter==1 (completion edge) or on flush.
- Issue:
  - On the issue edge the unit computes and latches the full result internally.
  - mult: signed 2*WIDTH product; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - multu: same as mult, unsigned.
  - div: signed, truncates toward zero; LO=quotient, HI=remainder; remainder takes the sign of the dividend.
  - divu: same as div, unsigned.
- Busy timing:
  - busy rises on the edge after issue and stays high for exactly MUL_CYCLES or DIV_CYCLES cycles.
  - HI/LO update and busy fall on the same completion edge.
  - From the cycle after completion, hi/lo show the new values.
- mthi/mtlo (start & ~flush in IDLE): hi or lo takes rs_val at the next edge; busy is not asserted.
- mfhi/mflo: rd_data = op[0] ? lo : hi, combinational, showing current register contents. rd_data=0 when op is not 000/001 or start=0.
- start while busy: ignored with no state change; the decoder's block term guarantees this does not occur in normal flow.
- start with op 000/001 while busy: still ignored, and rd_data still reflects current hi/lo.
- flush in RUN: returns to IDLE next edge, busy=0, hi/lo unchanged, div_zero not pulsed.
- flush & start in the same cycle: flush wins, nothing issues.
- Divide by zero:
  - Full DIV_CYCLES latency still applies.
  - hi/lo unchanged at completion.
  - div_zero=1 for exactly the completion cycle +1 (registered pulse).
- Signed overflow, MIN / -1: LO=MIN, HI=0, no flag.
- Width: all arithmetic uses WIDTH and 2*WIDTH-bit intermediates; no truncation except the documented HI/LO split.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).

Decomposition:
- Shared package/header mdu_defs holds the op encodings (MD_MULT=3'b100, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO) and state encodings (ST_IDLE, ST_RUN). The decoder uses the same constants.
- One sub-module, mdu_arith: purely combinational, takes op, rs_val and rt_val, and produces hi_next, lo_next and dz. The sign handling and the MIN/-1 and zero-divisor cases live there.
- mdu_seq keeps the FSM, counter, pending result, and the HI/LO registers.

Test Plan:
1. mult rs=0xFFFFFFFD, rt=7 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. multu rs=rt=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
3. Division results and latency:
   - div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu 7/2 -> LO=3, HI=1.
   - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. mthi 0x12, then mtlo 0x34, then divu 5/0 -> no busy for the mt ops; after 10 cycles div_zero high for 1 cycle, HI=0x12, LO=0x34. mfhi then gives rd_data=0x12 in the same cycle.
5. Cancellation and ignored starts:
   - div issued, flush at busy cycle 3 -> busy=0 next edge, HI/LO unchanged.
   - start mult during busy -> ignored; HI/LO reflect only the first op.
6. Reset cases:
   - rst asserted mid-division (no clock edge) -> hi=lo=0, busy=0 immediately.
   - Re-run case 1 with WIDTH=16, MUL_CYCLES=1 -> HI=0xFFFF, LO=0xFFEB, busy exactly 1 cycle.
